pipelined_control: RTL and testbench

//  Registered, handshaked RV32I(+M) decode/control stage: one-entry ID pipeline register between fetch and execute.

---
 rtl/pipelined_control_if.sv | 38 +++
 rtl/pipelined_control.sv | 124 ++++++++++++
 tb/tb_pipelined_control.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_if.sv
// pipelined_control_if: fetch-side request and execute-side control bundle of the decode stage.
interface pipelined_control_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  alu_1_src_o;
    logic        alu_2_src_o;
    logic        reg_write_o;
    logic        is_branch_o;
    logic        is_jal_o;
    logic        is_jalr_o;
    logic        mem_write_o;
    logic        mem_read_o;
    logic [1:0]  mem_width_o;
    logic        mem_sign_extend_o;
    logic [1:0]  reg_src_o;
    logic [3:0]  alu_op_o;
    logic        alu_flag_o;
    logic        illegal_o;
    logic        muldiv_busy_o;

    modport master (
        output in_valid_i, instr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_1_src_o, alu_2_src_o, reg_write_o, is_branch_o,
               is_jal_o, is_jalr_o, mem_write_o, mem_read_o, mem_width_o, mem_sign_extend_o,
               reg_src_o, alu_op_o, alu_flag_o, illegal_o, muldiv_busy_o
    );

    modport slave (
        input  in_valid_i, instr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_1_src_o, alu_2_src_o, reg_write_o, is_branch_o,
               is_jal_o, is_jalr_o, mem_write_o, mem_read_o, mem_width_o, mem_sign_extend_o,
               reg_src_o, alu_op_o, alu_flag_o, illegal_o, muldiv_busy_o
    );
endinterface

// File: rtl/pipelined_control.sv
// pipelined_control: RV32I(+M) decode stage with a one-entry ID register that holds M ops for their latency.
module pipelined_control #(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input logic clk_i,
    input logic rst_i,
    pipelined_control_if.slave bus
);
    localparam int MAX_LAT = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES > 1 ? DIV_CYCLES - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [1:0] alu_1_src;
        logic       alu_2_src;
        logic       reg_write;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] mem_width;
        logic       mem_sign_extend;
        logic [1:0] reg_src;
        logic [3:0] alu_op;
        logic       alu_flag;
        logic       illegal;
    } ctrl_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctrl_t         ctrl_q, ctrl_d, dec;
    logic [6:0]    opc, f7;
    logic [2:0]    f3;
    logic          op_lui, op_auipc, op_jal, op_jalr, op_br, op_ld, op_st, op_imm, op_reg;
    logic          regari_ok, illegal, m_op, m_wait, accept;

    assign opc      = bus.instr_i[6:0];
    assign f3       = bus.instr_i[14:12];
    assign f7       = bus.instr_i[31:25];
    assign op_lui   = opc == 7'b0110111;
    assign op_auipc = opc == 7'b0010111;
    assign op_jal   = opc == 7'b1101111;
    assign op_jalr  = opc == 7'b1100111;
    assign op_br    = opc == 7'b1100011;
    assign op_ld    = opc == 7'b0000011;
    assign op_st    = opc == 7'b0100011;
    assign op_imm   = opc == 7'b0010011;
    assign op_reg   = opc == 7'b0110011;

    assign regari_ok = f7 == 7'b0000000
                    || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    || (f7 == 7'b0000001 && ENABLE_M != 0);
    assign illegal = !(op_lui || op_auipc || op_jal || op_jalr || op_br || op_ld || op_st || op_imm || op_reg)
                  || (op_reg && !regari_ok);
    assign m_op    = op_reg && f7 == 7'b0000001 && ENABLE_M != 0;
    assign m_wait  = m_op && (f3[2] ? DIV_CYCLES > 1 : MUL_CYCLES > 1);
    assign accept  = bus.in_valid_i && bus.in_ready_o;

    // Illegal words only arise from unknown opcodes or REGARI, so branch/jump/mem flags need no extra gating.
    always_comb begin
        dec.alu_1_src       = op_auipc ? 2'b10 : op_lui ? 2'b01 : 2'b00;
        dec.alu_2_src       = !(op_reg || op_br);
        dec.reg_write       = !(op_st || op_br || illegal);
        dec.is_branch       = op_br;
        dec.is_jal          = op_jal;
        dec.is_jalr         = op_jalr;
        dec.mem_write       = op_st;
        dec.mem_read        = op_ld;
        dec.mem_width       = f3[1:0];
        dec.mem_sign_extend = !f3[2];
        dec.reg_src         = (op_jal || op_jalr) ? 2'b10 : op_ld ? 2'b01 : 2'b00;
        dec.alu_op          = op_reg ? {f7[0], f3} : op_imm ? {1'b0, f3} : 4'b0000;
        dec.alu_flag        = f7[5] && (((op_reg || op_imm) && f3 == 3'b101) || (op_reg && f3 == 3'b000));
        dec.illegal         = illegal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        if (state_q == WAIT) begin
            state_d = cnt_q == '0 ? HOLD : WAIT;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
        end else if (accept) begin
            state_d = m_wait ? WAIT : HOLD;
            cnt_d   = m_wait ? (f3[2] ? DIV_LD : MUL_LD) : '0;
            ctrl_d  = dec;
        end else if (state_q == HOLD && bus.out_ready_i) begin
            state_d = IDLE;
        end
        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
        end
    end

    always_comb begin
        bus.in_ready_o    = !rst_i && !bus.flush_i && (state_q == IDLE || (state_q == HOLD && bus.out_ready_i));
        bus.out_valid_o   = state_q == HOLD;
        bus.muldiv_busy_o = state_q == WAIT;
        {bus.alu_1_src_o, bus.alu_2_src_o, bus.reg_write_o, bus.is_branch_o, bus.is_jal_o,
         bus.is_jalr_o, bus.mem_write_o, bus.mem_read_o, bus.mem_width_o, bus.mem_sign_extend_o,
         bus.reg_src_o, bus.alu_op_o, bus.alu_flag_o, bus.illegal_o} = ctrl_q;
    end
endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: scoreboard bench for the decode stage; a second instance covers ENABLE_M=0.
module tb_pipelined_control;
    logic clk = 0;
    logic rst = 1;
    bit   mon_en = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [19:0] c;
        int          due;
    } exp_t;
    exp_t q[$];

    pipelined_control_if bus ();
    pipelined_control_if bus_n ();

    pipelined_control u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    pipelined_control #(.ENABLE_M(0)) u_dut_nom (.clk_i(clk), .rst_i(rst), .bus(bus_n));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [19:0] vec, vec_n;
    assign vec = {bus.alu_1_src_o, bus.alu_2_src_o, bus.reg_write_o, bus.is_branch_o, bus.is_jal_o,
                  bus.is_jalr_o, bus.mem_write_o, bus.mem_read_o, bus.mem_width_o, bus.mem_sign_extend_o,
                  bus.reg_src_o, bus.alu_op_o, bus.alu_flag_o, bus.illegal_o};
    assign vec_n = {bus_n.alu_1_src_o, bus_n.alu_2_src_o, bus_n.reg_write_o, bus_n.is_branch_o, bus_n.is_jal_o,
                    bus_n.is_jalr_o, bus_n.mem_write_o, bus_n.mem_read_o, bus_n.mem_width_o, bus_n.mem_sign_extend_o,
                    bus_n.reg_src_o, bus_n.alu_op_o, bus_n.alu_flag_o, bus_n.illegal_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [19:0] model(input logic [31:0] ins, input bit m_en);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [1:0] a1 = 2'b00, rs = 2'b00;
        logic [3:0] aop = 4'b0000;
        logic a2 = 1, rw = 1, br = 0, jl = 0, jr = 0, mw = 0, mr = 0, fl = 0, il = 0;
        case (op)
            7'b0110111: a1 = 2'b01;
            7'b0010111: a1 = 2'b10;
            7'b1101111: begin jl = 1; rs = 2'b10; end
            7'b1100111: begin jr = 1; rs = 2'b10; end
            7'b1100011: begin br = 1; a2 = 0; rw = 0; end
            7'b0000011: begin mr = 1; rs = 2'b01; end
            7'b0100011: begin mw = 1; rw = 0; end
            7'b0010011: begin aop = {1'b0, f3}; fl = f3 == 3'b101 && f7[5]; end
            7'b0110011: begin
                a2  = 0;
                aop = {f7[0], f3};
                fl  = (f3 == 3'b101 || f3 == 3'b000) && f7[5];
                il  = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || (f7 == 7'h01 && m_en));
            end
            default: il = 1;
        endcase
        if (il) {rw, mw, mr, br, jl, jr} = 6'b0;
        return {a1, a2, rw, br, jl, jr, mw, mr, f3[1:0], ~f3[2], rs, aop, fl, il};
    endfunction

    function automatic int lat(input logic [31:0] ins);
        if (ins[6:0] == 7'b0110011 && ins[31:25] == 7'h01) return ins[14] ? 8 : 3;
        return 1;
    endfunction

    always @(negedge clk) begin
        logic ev, eb, er;
        if (mon_en) begin
            ev = q.size() != 0 && cyc >= q[0].due;
            eb = q.size() != 0 && cyc < q[0].due;
            er = !rst && !bus.flush_i && (q.size() == 0 || (ev && bus.out_ready_i));
            check("out_valid", bus.out_valid_o, ev);
            check("busy", bus.muldiv_busy_o, eb);
            check("in_ready", bus.in_ready_o, er);
            if (ev && bus.out_valid_o) check("ctrl", vec, q[0].c);
            if (rst || bus.flush_i) q.delete();
            else begin
                if (ev && bus.out_ready_i) void'(q.pop_front());
                if (bus.in_valid_i && bus.in_ready_o) q.push_back('{model(bus.instr_i, 1), cyc + lat(bus.instr_i)});
            end
        end
    end

    task automatic send(input logic [31:0] ins);
        int n = 0;
        bus.in_valid_i = 1;
        bus.instr_i = ins;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready_o && n < 50);
        check("accept", bus.in_ready_o, 1);
        @(posedge clk);
        #1 bus.in_valid_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1 check("drain", q.size(), 0);
    endtask

    logic [31:0] table_ins [10] = '{32'h000010B7, 32'h00001097, 32'h0000006F, 32'h000080E7, 32'h00208063,
                                    32'h0020A023, 32'h00110093, 32'h0000C083, 32'h023160B3, 32'h403150B3};

    initial begin
        bus.in_valid_i = 0; bus.instr_i = 0; bus.flush_i = 0; bus.out_ready_i = 1;
        bus_n.in_valid_i = 0; bus_n.instr_i = 0; bus_n.flush_i = 0; bus_n.out_ready_i = 1;
        @(posedge clk);
        #1 mon_en = 1;
        @(posedge clk);
        #1 rst = 0;
        check("rst_ctrl", vec, 0);
        send(32'h003100B3);
        send(32'h403100B3);
        send(32'h4031D093);
        drain();
        send(32'h023100B3);
        drain();
        send(32'h023140B3);
        drain();
        send(32'h0000007F);
        send(32'h403110B3);
        drain();
        foreach (table_ins[i]) send(table_ins[i]);
        drain();
        bus.out_ready_i = 0;
        send(32'h0000A083);
        repeat (5) @(posedge clk);
        #1 bus.out_ready_i = 1;
        drain();
        send(32'h023140B3);
        repeat (3) @(posedge clk);
        #1 bus.flush_i = 1;
        @(posedge clk);
        #1 bus.flush_i = 0;
        send(32'h003100B3);
        drain();
        send(32'h023140B3);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        check("rst_mid_ctrl", vec, 0);
        send(32'h023100B3);
        drain();
        bus_n.in_valid_i = 1;
        bus_n.instr_i = 32'h023100B3;
        @(negedge clk);
        check("nom_ready", bus_n.in_ready_o, 1);
        @(posedge clk);
        #1 bus_n.in_valid_i = 0;
        @(negedge clk);
        check("nom_valid", bus_n.out_valid_o, 1);
        check("nom_busy", bus_n.muldiv_busy_o, 0);
        check("nom_ctrl", vec_n, model(32'h023100B3, 0));
        @(posedge clk);
        #1 $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
